// File: rtl/yarvi_alu_seq_if.sv
// yarvi_alu_seq_if: issue/result handshake bundle for the sequential YARVI ALU.
// master = producer of operations and consumer of results (decode/writeback side),
// slave  = the ALU itself.
interface yarvi_alu_seq_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic            in_insn30;
    logic [2:0]      in_funct3;
    logic            in_word;
    logic [XLEN-1:0] in_op1;
    logic [XLEN-1:0] in_op2;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [TAGW-1:0] out_tag;

    modport master (
        output in_valid, in_insn30, in_funct3, in_word, in_op1, in_op2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_insn30, in_funct3, in_word, in_op1, in_op2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/yarvi_alu_seq.sv
// yarvi_alu_seq: handshaked YARVI ALU with an iterative shifter that moves up to
// SHIFT_STEP bits per cycle. Non-shift ops complete in one cycle; results are held
// in an output register until the consumer takes them.
// Optional RV64 W-ops are built only when the macro YARVI_ALU_WORD_EN is defined
// and XLEN == 64; otherwise in_word is ignored.
module yarvi_alu_seq #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned TAGW       = 5
) (
    input logic              clock,
    input logic              reset_n,
    input logic              flush,
    yarvi_alu_seq_if.slave   bus
);

    localparam int unsigned RemW = $clog2(XLEN);
    // One extra bit so that SHIFT_STEP == XLEN is representable for the compare.
    localparam logic [RemW:0] StepLim = (RemW + 1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            shl_q, shl_d;
    logic            sra_q, sra_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;

    logic            ready;
    logic            accept;
    logic            is_shift;
    logic [2:0]      f3;
    logic            insn30;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] alu_raw;
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] pre_op1;
    logic [XLEN-1:0] zero_out;
    logic [RemW-1:0] shamt;
    logic [RemW-1:0] step_amt;
    logic [RemW-1:0] rem_next;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] shift_out;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return XLEN'($signed(v[31:0]));
    endfunction

    assign f3       = bus.in_funct3;
    assign insn30   = bus.in_insn30;
    assign op1      = bus.in_op1;
    assign op2      = bus.in_op2;
    assign is_shift = (f3[1:0] == 2'b01);

`ifdef YARVI_ALU_WORD_EN
    localparam bit WordEn = (XLEN == 64);

    logic word_in;
    logic word_q, word_d;

    // W semantics only apply to ADD/SUB and the shifts.
    assign word_in = WordEn & bus.in_word & ((f3 == 3'd0) | (f3 == 3'd1) | (f3 == 3'd5));

    // Remembers whether the in-flight shift needs a final 32-bit sign extension.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= 1'b0;
        end else begin
            word_q <= word_d;
        end
    end
`else
    logic word_in;
    logic word_q;
    logic unused_word;

    assign word_in     = 1'b0;
    assign word_q      = 1'b0;
    assign unused_word = bus.in_word;
`endif

    // Single-cycle ops: add/sub, compares and logic.
    always_comb begin
        sum     = op1 + (op2 ^ {XLEN{insn30}}) + XLEN'(insn30);
        alu_raw = '0;
        unique case (f3)
            3'd0:    alu_raw = sum;
            3'd2:    alu_raw = XLEN'($signed(op1) < $signed(op2));
            3'd3:    alu_raw = XLEN'(op1 < op2);
            3'd4:    alu_raw = op1 ^ op2;
            3'd6:    alu_raw = op1 | op2;
            3'd7:    alu_raw = op1 & op2;
            default: alu_raw = '0;
        endcase
        alu_val = word_in ? sext32(alu_raw) : alu_raw;
    end

    // Shift launch: pre-extend the operand for W right shifts and pick the amount.
    always_comb begin
        pre_op1 = op1;
        if (word_in && (f3 == 3'd5)) begin
            pre_op1 = insn30 ? sext32(op1) : XLEN'(op1[31:0]);
        end
        shamt    = word_in ? RemW'(op2[4:0]) : op2[RemW-1:0];
        zero_out = word_in ? sext32(pre_op1) : pre_op1;
    end

    // One shifter iteration: a small mux over 0..SHIFT_STEP fixed shifts.
    always_comb begin
        step_amt = ({1'b0, rem_q} < StepLim) ? rem_q : StepLim[RemW-1:0];
        rem_next = rem_q - step_amt;
        shifted  = acc_q;
        for (int k = 1; k <= int'(SHIFT_STEP); k++) begin
            if (int'(step_amt) == k) begin
                if (shl_q) begin
                    shifted = acc_q << k;
                end else if (sra_q) begin
                    shifted = XLEN'($signed(acc_q) >>> k);
                end else begin
                    shifted = acc_q >> k;
                end
            end
        end
        shift_out = word_q ? sext32(shifted) : shifted;
    end

    assign ready  = !flush && ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    assign accept = bus.in_valid && ready;

    // Next-state: flush wins, then sequencing, then a launch overrides the drain.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        tag_d     = tag_q;
        shl_d     = shl_q;
        sra_d     = sra_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;
`ifdef YARVI_ALU_WORD_EN
        word_d    = word_q;
`endif

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StShift: begin
                    acc_d = shifted;
                    rem_d = rem_next;
                    if (rem_next == '0) begin
                        result_d  = shift_out;
                        out_tag_d = tag_q;
                        state_d   = StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (accept) begin
                if (is_shift) begin
                    acc_d = pre_op1;
                    rem_d = shamt;
                    tag_d = bus.in_tag;
                    shl_d = ~f3[2];
                    sra_d = insn30;
`ifdef YARVI_ALU_WORD_EN
                    word_d = word_in;
`endif
                    if (shamt == '0) begin
                        result_d  = zero_out;
                        out_tag_d = bus.in_tag;
                        state_d   = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end else begin
                    result_d  = alu_val;
                    out_tag_d = bus.in_tag;
                    state_d   = StDone;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            rem_q     <= '0;
            tag_q     <= '0;
            shl_q     <= 1'b0;
            sra_q     <= 1'b0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            tag_q     <= tag_d;
            shl_q     <= shl_d;
            sra_q     <= sra_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = result_q;
    assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_yarvi_alu_seq.sv
// tb_yarvi_alu_seq: directed vector table, randomized ops against a behavioural
// model, and hand sequences for backpressure, flush and mid-shift reset.
// Build with YARVI_ALU_WORD_EN to exercise the 64-bit W-op configuration.
module tb_yarvi_alu_seq;

`ifdef YARVI_ALU_WORD_EN
    localparam int unsigned XLEN = 64;
`else
    localparam int unsigned XLEN = 32;
`endif
    localparam int unsigned STEP = 4;
    localparam int unsigned TAGW = 5;

    typedef struct {
        logic [2:0]      f3;
        logic            i30;
        logic            w;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [TAGW-1:0] tag;
    } res_t;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;
    int   checks = 0;
    int   passed = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    yarvi_alu_seq_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

    yarvi_alu_seq #(
        .XLEN      (XLEN),
        .SHIFT_STEP(STEP),
        .TAGW      (TAGW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .flush  (flush),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit word_applies(input logic [2:0] f3, input logic w);
        return w && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
    endfunction

    // Architectural result, from the ISA definitions.
    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f3, input logic i30,
                                                   input logic w, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        int              sh;
        logic [31:0]     a32, b32, r32;
        logic [XLEN-1:0] r;
        a32 = a[31:0];
        b32 = b[31:0];
        if (word_applies(f3, w)) begin
            sh = int'(b32 % 32);
            case (f3)
                3'd0:    r32 = i30 ? a32 - b32 : a32 + b32;
                3'd1:    r32 = a32 << sh;
                default: r32 = i30 ? 32'($signed(a32) >>> sh) : a32 >> sh;
            endcase
            return XLEN'($signed(r32));
        end
        sh = int'(b % XLEN);
        case (f3)
            3'd0:    r = i30 ? a - b : a + b;
            3'd1:    r = a << sh;
            3'd2:    r = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
            3'd3:    r = (a < b) ? XLEN'(1) : '0;
            3'd4:    r = a ^ b;
            3'd5:    r = i30 ? XLEN'($signed(a) >>> sh) : a >> sh;
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Cycles from accept edge to first edge that sees out_valid.
    function automatic int ref_lat(input logic [2:0] f3, input logic w, input logic [XLEN-1:0] b);
        int sh;
        if (f3 != 3'd1 && f3 != 3'd5) return 1;
        sh = word_applies(f3, w) ? int'(b[31:0] % 32) : int'(b % XLEN);
        if (sh == 0) return 1;
        return 1 + (sh + int'(STEP) - 1) / int'(STEP);
    endfunction

    task automatic add_vec(input logic [2:0] f3, input logic i30, input logic w,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [TAGW-1:0] tag, input logic [XLEN-1:0] exp,
                           input int lat);
        vec_t v;
        v.f3 = f3; v.i30 = i30; v.w = w; v.a = a; v.b = b; v.tag = tag; v.exp = exp; v.lat = lat;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [2:0] f3, input logic i30, input logic w,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAGW-1:0] tag);
        bus.in_funct3 = f3;
        bus.in_insn30 = i30;
        bus.in_word   = w;
        bus.in_op1    = a;
        bus.in_op2    = b;
        bus.in_tag    = tag;
    endtask

    // Issue one op from idle with out_ready high and check latency, result and tag.
    task automatic run_op(input string name, input vec_t v);
        int   cyc;
        logic busy_ready;
        drive(v.f3, v.i30, v.w, v.a, v.b, v.tag);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check({name, "_accept"}, bus.in_ready, 1'b1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        busy_ready = 1'b0;
        while (!bus.out_valid && cyc < 4 * int'(XLEN)) begin
            busy_ready |= bus.in_ready;
            @(posedge clock); #1;
            cyc++;
        end
        check({name, "_lat"}, 64'(cyc), 64'(v.lat));
        check({name, "_res"}, 64'(bus.out_result), 64'(v.exp));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(v.tag));
        if (v.lat > 1) check({name, "_busy"}, busy_ready, 1'b0);
        @(posedge clock); #1;
    endtask

    initial begin
        res_t            q[$];
        res_t            e;
        int              sent, got;
        logic            seen;
        logic [63:0]     r1, r2;
        vec_t            v;

`ifdef YARVI_ALU_WORD_EN
        add_vec(3'd5, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 5'd1, 64'hFFFF_FFFF_F800_0000, 2);
        add_vec(3'd0, 1'b0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 5'd2, 64'hFFFF_FFFF_8000_0000, 1);
        add_vec(3'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 5'd3, 64'h0000_0000_0800_0000, 2);
        add_vec(3'd1, 1'b0, 1'b1, 64'd1, 64'd31, 5'd4, 64'hFFFF_FFFF_8000_0000, 9);
        add_vec(3'd0, 1'b1, 1'b1, 64'd0, 64'd1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        add_vec(3'd1, 1'b0, 1'b0, 64'd1, 64'd40, 5'd6, 64'h0000_0100_0000_0000, 11);
        add_vec(3'd4, 1'b0, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 5'd7,
                64'hFFFF_FFFF_FFFF_FFFF, 1);
        add_vec(3'd5, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 5'd8, 64'hFFFF_FFFF_8000_0000, 1);
        add_vec(3'd5, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 17);
`else
        add_vec(3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 5'd3, 32'hFFFF_FFFE, 1);
        add_vec(3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd31, 5'd5, 32'hFFFF_FFFF, 9);
        add_vec(3'd1, 1'b0, 1'b0, 32'd1, 32'd20, 5'd7, 32'h0010_0000, 6);
        add_vec(3'd5, 1'b0, 1'b0, 32'hF000_0000, 32'd5, 5'd9, 32'h0780_0000, 3);
        add_vec(3'd1, 1'b0, 1'b0, 32'h0000_1234, 32'd32, 5'd2, 32'h0000_1234, 1);
        add_vec(3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd10, 32'd1, 1);
        add_vec(3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'd0, 1);
        add_vec(3'd4, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd12, 32'h0FF0_0FF0, 1);
        add_vec(3'd6, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd13, 32'hFFFF_F0F0, 1);
        add_vec(3'd7, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd14, 32'hF000_F000, 1);
        add_vec(3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd15, 32'd0, 1);
        add_vec(3'd5, 1'b1, 1'b0, 32'h7FFF_FFF0, 32'd4, 5'd16, 32'h07FF_FFFF, 2);
        add_vec(3'd1, 1'b0, 1'b0, 32'd3, 32'd3, 5'd17, 32'h0000_0018, 2);
`endif

        reset_n = 1'b0;
        flush   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, 1'b0, 1'b0, '0, '0, '0);
        #12;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_result", 64'(bus.out_result), 64'd0);
        check("rst_tag", 64'(bus.out_tag), 64'd0);
        check("rst_ready", bus.in_ready, 1'b1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            v.f3  = 3'($urandom_range(0, 7));
            v.i30 = 1'($urandom_range(0, 1));
`ifdef YARVI_ALU_WORD_EN
            v.w   = 1'($urandom_range(0, 1));
`else
            v.w   = 1'b0;
`endif
            v.a   = r1[XLEN-1:0];
            v.b   = r2[XLEN-1:0];
            v.tag = TAGW'($urandom());
            v.exp = ref_result(v.f3, v.i30, v.w, v.a, v.b);
            v.lat = ref_lat(v.f3, v.w, v.b);
            run_op($sformatf("rnd%0d", i), v);
        end

        // Three back-to-back ADDs; consumer stalls for two cycles after the first result.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.out_ready = !(cyc == 1 || cyc == 2);
            bus.in_valid  = (sent < 3);
            drive(3'd0, 1'b0, 1'b0, XLEN'(10 * (sent + 1)), XLEN'(sent + 1), TAGW'(11 + sent));
            #1;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("bp_spurious", bus.out_valid, 1'b0);
                end else begin
                    check("bp_res", 64'(bus.out_result), 64'(q[0].res));
                    check("bp_tag", 64'(bus.out_tag), 64'(q[0].tag));
                    if (bus.out_ready) begin
                        e = q.pop_front();
                        got++;
                    end else begin
                        check("bp_hold_ready", bus.in_ready, 1'b0);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.res = ref_result(3'd0, 1'b0, 1'b0, bus.in_op1, bus.in_op2);
                e.tag = bus.in_tag;
                q.push_back(e);
                sent++;
            end
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
        check("bp_count", 64'(got), 64'd3);
        check("bp_idle", bus.out_valid, 1'b0);

        // Flush two cycles into a long shift, with an ADD offered during the flush.
        bus.out_ready = 1'b1;
        drive(3'd1, 1'b0, 1'b0, XLEN'(1), XLEN'(20), 5'd21);
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        flush = 1'b1;
        drive(3'd0, 1'b0, 1'b0, XLEN'(1), XLEN'(2), 5'd22);
        bus.in_valid = 1'b1;
        #1;
        check("flush_ready", bus.in_ready, 1'b0);
        @(posedge clock); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_valid", bus.out_valid, 1'b0);
        check("flush_idle", bus.in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            seen |= bus.out_valid;
        end
        check("flush_no_result", seen, 1'b0);

        // Asynchronous reset in the middle of a shift.
        drive(3'd1, 1'b0, 1'b0, XLEN'(1), XLEN'(20), 5'd23);
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_ready", bus.in_ready, 1'b1);
        check("arst_result", 64'(bus.out_result), 64'd0);
        check("arst_tag", 64'(bus.out_tag), 64'd0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            seen |= bus.out_valid;
        end
        check("arst_no_result", seen, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/yarvi_alu_seq.md
# yarvi_alu_seq

Parametrised, handshaked successor to the combinational YARVI ALU. It supports XLEN of 32 or 64 and replaces the single-cycle barrel shifter with an iterative shifter that moves SHIFT_STEP bits per cycle. Optional RV64 word (`*W`) operations are included. The block sits between register read and writeback: the decode stage pushes operations in, and writeback pops results out through a valid/ready pair.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64.
- `SHIFT_STEP`, default 4: maximum bits shifted per cycle; a power of 2 with 1 ≤ SHIFT_STEP ≤ XLEN.
- `TAGW`, default 5: width of the opaque tag carried with each operation.
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous abort of any in-flight or held operation.
- `in_valid`  in  1: operation offered.
- `in_ready`  out  1: block can accept this cycle.
- `in_insn30`  in  1: SUB / SRA select.
- `in_funct3`  in  3: 0 ADDSUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SR_, 6 OR, 7 AND.
- `in_word`  in  1: RV64 W-op select.
- `in_op1`, `in_op2`  in  XLEN: operands.
- `in_tag`  in  TAGW: returned unchanged with the result.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `out_result`  out  XLEN: result.
- `out_tag`  out  TAGW: tag of the result.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- `in_ready` = !flush & (IDLE | (DONE & out_ready)).
- An accept (`in_valid & in_ready`) captures the operands and tag.
- Non-shift funct3 values compute combinationally and are registered into `out_result`; the next state is DONE.
- ADDSUB: op1 + (op2 ^ {XLEN{insn30}}) + insn30, modulo 2^XLEN.
- SLT / SLTU: signed / unsigned op1 < op2, zero-extended to XLEN.
- AND, OR, XOR: bitwise.
- Shifts load the accumulator with op1 and `rem` with the shift amount op2[$clog2(XLEN)-1:0].
  - If rem == 0, the next state is DONE with result = op1.
  - Otherwise the next state is SHIFT.
- SHIFT, each cycle: shift the accumulator by s = min(rem, SHIFT_STEP), then rem -= s.
  - SLL and SRL fill with zeros; SRA fills with the accumulator MSB.
  - When rem reaches 0, the accumulator is written to `out_result` and the next state is DONE.
- DONE: `out_valid` = 1. The result and tag stay stable until `out_ready`.
  - On `out_ready` the block accepts a new operation in the same cycle, or returns to IDLE if none is offered.
- `flush` has priority over everything: the next state is IDLE, `out_valid` drops next cycle, and any same-cycle input is not accepted (`in_ready` = 0).
- An accept with no flush while in DONE with `out_ready`: the pop and push happen in the same cycle.

## Timing
- Reset values: `out_valid` 0, `out_result` 0, `out_tag` 0, state IDLE, so `in_ready` = 1 when flush = 0.
- Non-shift, or a shift with amount 0, accepted at edge T: `out_valid` is high from T+1.
- Shift with amount n > 0, accepted at edge T: `out_valid` is high from T+1+ceil(n/SHIFT_STEP).
- Throughput for non-shift ops with `out_ready` held high is 1 per cycle.
- Asserting reset mid-operation clears all state immediately; no result is emitted.
- `out_result` and `out_tag` change only on entry to DONE.

## Configuration
- `YARVI_ALU_WORD_EN` defined, with XLEN = 64: `in_word` selects W semantics.
  - Shift amount is op2[4:0].
  - SLLW shifts op1; SRLW pre-zero-extends op1[31:0]; SRAW pre-sign-extends op1[31:0].
  - ADDW, SUBW, SLLW, SRLW and SRAW results are sign-extended from bit 31.
  - `in_word` is ignored for funct3 2, 3, 4, 6 and 7.
- `YARVI_ALU_WORD_EN` undefined, or XLEN = 32: `in_word` is ignored and no W logic is built.

## Test plan
- XLEN=32, SHIFT_STEP=4, `out_ready`=1. Offer SUB op1=5, op2=7, tag=3 at T → `out_valid` at T+1 with `out_result`=0xFFFFFFFE and `out_tag`=3.
- XLEN=32, SHIFT_STEP=4. Offer SRA op1=0x80000000, op2=31 at T → `in_ready`=0 during T+1..T+8; `out_valid` at T+9 with `out_result`=0xFFFFFFFF.
- Offer 3 back-to-back ADDs with `out_ready` low for 2 cycles after the first result → the first result is held stable and `in_ready`=0 while it is held; all 3 results emerge in order with correct tags and none are lost.
- Offer SLL op1=1, op2=20 (SHIFT_STEP=4); assert `flush` 2 cycles later → no `out_valid`; IDLE on the next cycle. A concurrent ADD offered during the flush is not accepted.
- XLEN=64 with `YARVI_ALU_WORD_EN`. Offer SRAW op1=0x0000000080000000, op2=4 → 0xFFFFFFFFF8000000. Offer ADDW 0x7FFFFFFF+1 → 0xFFFFFFFF80000000.
- Drive `reset_n` low mid-SHIFT → `out_valid` is 0 and `in_ready` is 1 immediately; no stale result appears after release.
